// File: rtl/writeback_pkg.sv
// Shared encodings for the Pillar writeback stage: opcodes, load funct3 codes,
// control-sequencer stage numbers and writeback FSM states.
package writeback_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_S    = 7'b0100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_LOAD = 7'b0000011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] STAGE_FETCH  = 3'd0;
    localparam logic [2:0] STAGE_DECODE = 3'd1;
    localparam logic [2:0] STAGE_EXE    = 3'd2;
    localparam logic [2:0] STAGE_MEM    = 3'd3;
    localparam logic [2:0] STAGE_WB     = 3'd4;

    typedef enum logic [2:0] {
        WB_IDLE     = 3'd0,
        WB_WAIT_MEM = 3'd1,
        WB_SETUP    = 3'd2,
        WB_STROBE   = 3'd3,
        WB_DONE     = 3'd4
    } wb_state_t;

    function automatic logic is_alu_op(input logic [6:0] opcode);
        return (opcode == OP_R) || (opcode == OP_I);
    endfunction

endpackage

// File: rtl/writeback_load_align.sv
// Load data formatting: byte/halfword lane select with sign or zero extension.
// Only built when WRITEBACK_LOAD_EN is defined.
`ifdef WRITEBACK_LOAD_EN
module writeback_load_align
    import writeback_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        case (offset)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = 8'h00;
        endcase
        // Halfword loads ignore offset[0]; misalignment is not trapped here.
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

        data = rdata;
        case (funct3)
            F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  data = {24'h000000, byte_sel};
            F3_LH:   data = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  data = {16'h0000, half_sel};
            F3_LW:   data = rdata;
            default: data = rdata;
        endcase
    end

endmodule
`endif

// File: rtl/writeback.sv
// Pillar writeback stage: selects the result and drives the register-file write port.
// Optional load path (WAIT_MEM, load formatting) is built when WRITEBACK_LOAD_EN is defined.
//
// state    | meaning
// IDLE     | waiting for a fresh entry into STAGE_WB
// WAIT_MEM | load issued, mem_req_o high until mem_valid_i
// SETUP    | wd_o/rd_o driven, strobe on next cycle
// STROBE   | wd_q_o high for one cycle
// DONE     | done_o high for one cycle
module writeback
    import writeback_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  stage_i,
    input  logic [31:0] ir_i,
    input  logic [31:0] alu_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_valid_i,
    output logic        mem_req_o,
    output logic [31:0] wd_o,
    output logic [4:0]  rd_o,
    output logic        wd_q_o,
    output logic        done_o
);

    wb_state_t  state;
    logic [2:0] stage_q;
    logic       entry;

    // Edge-triggered entry so a stage held at WB does not retrigger.
    assign entry = (state == WB_IDLE) && (stage_i == STAGE_WB) && (stage_q != STAGE_WB);

`ifdef WRITEBACK_LOAD_EN
    logic [4:0]  rd_q;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic [31:0] load_data;
    logic        mem_req_q;

    writeback_load_align load_align (
        .rdata  (mem_rdata_i),
        .funct3 (funct3_q),
        .offset (offset_q),
        .data   (load_data)
    );

    assign mem_req_o = mem_req_q;
`else
    logic unused_mem;
    assign unused_mem = ^{mem_rdata_i, mem_valid_i};
    assign mem_req_o  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= WB_IDLE;
            stage_q <= 3'd0;
            wd_o    <= 32'h0;
            rd_o    <= 5'd0;
            wd_q_o  <= 1'b0;
            done_o  <= 1'b0;
`ifdef WRITEBACK_LOAD_EN
            rd_q      <= 5'd0;
            funct3_q  <= 3'd0;
            offset_q  <= 2'd0;
            mem_req_q <= 1'b0;
`endif
        end else begin
            stage_q <= stage_i;
            wd_q_o  <= 1'b0;
            done_o  <= 1'b0;
            case (state)
                WB_IDLE: begin
                    if (entry) begin
                        if (ir_i[11:7] == 5'd0) begin
                            done_o <= 1'b1;
                            state  <= WB_DONE;
                        end else if (is_alu_op(ir_i[6:0])) begin
                            wd_o  <= alu_i;
                            rd_o  <= ir_i[11:7];
                            state <= WB_SETUP;
                        end else if (ir_i[6:0] == OP_LUI) begin
                            wd_o  <= {ir_i[31:12], 12'h000};
                            rd_o  <= ir_i[11:7];
                            state <= WB_SETUP;
`ifdef WRITEBACK_LOAD_EN
                        end else if (ir_i[6:0] == OP_LOAD) begin
                            rd_q      <= ir_i[11:7];
                            funct3_q  <= ir_i[14:12];
                            offset_q  <= alu_i[1:0];
                            mem_req_q <= 1'b1;
                            state     <= WB_WAIT_MEM;
`endif
                        end else begin
                            done_o <= 1'b1;
                            state  <= WB_DONE;
                        end
                    end
                end
`ifdef WRITEBACK_LOAD_EN
                WB_WAIT_MEM: begin
                    if (mem_valid_i) begin
                        wd_o      <= load_data;
                        rd_o      <= rd_q;
                        mem_req_q <= 1'b0;
                        state     <= WB_SETUP;
                    end
                end
`endif
                WB_SETUP: begin
                    wd_q_o <= 1'b1;
                    state  <= WB_STROBE;
                end
                WB_STROBE: begin
                    done_o <= 1'b1;
                    state  <= WB_DONE;
                end
                WB_DONE: begin
                    state <= WB_IDLE;
                end
                default: begin
                    state <= WB_IDLE;
                end
            endcase
        end
    end

endmodule
